sr_cmd_encoder: RTL and testbench

//   Transmit side of the 2-bit set/reset command interface used by our SR storage flops.

---
 rtl/sr_cmd_encoder_if.sv | 24 ++
 rtl/sr_cmd_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_sr_cmd_encoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_cmd_encoder_if.sv
// Target-bit stream in, set/clear/hold command and status out for the SR command encoder.
// master drives targets and force_en; slave is the encoder.
interface sr_cmd_encoder_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       force_en;
  logic [1:0] cmd;
  logic       cmd_active;
  logic       q_model;
  logic       busy;
  logic [7:0] cmd_count;
  logic [7:0] elide_count;

  modport master (
    output in_valid, in_bit, force_en,
    input  in_ready, cmd, cmd_active, q_model, busy, cmd_count, elide_count
  );

  modport slave (
    input  in_valid, in_bit, force_en,
    output in_ready, cmd, cmd_active, q_model, busy, cmd_count, elide_count
  );
endinterface

// File: rtl/sr_cmd_encoder.sv
// Set/clear command encoder for SR flops: buffered target bits become minimal 10/01 pulses.
// First cmd one cycle after accept, held PULSE cycles; in_ready drops only when the FIFO is full.

module sr_cmd_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // full comes from the registered count, so a same-cycle pop never frees a slot early
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module sr_cmd_encoder #(
  parameter int   DEPTH   = 4,
  parameter int   PULSE   = 2,
  parameter int   SETTLE  = 1,
  parameter logic RESET_Q = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_cmd_encoder_if.slave    bus
);
  localparam int PW = $clog2(PULSE + 1);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          active_q, active_d;
  logic          qm_q, qm_d;
  logic          tgt_q, tgt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [7:0]    ccnt_q, ccnt_d;
  logic [7:0]    ecnt_q, ecnt_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_dat;
  logic          pop;
  logic          issue;

  sr_cmd_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.in_valid),
    .push_dat (bus.in_bit),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // a head entry needs a pulse when it differs from the tracked flop value or is forced
  assign issue = !fifo_empty && ((fifo_dat != qm_q) || bus.force_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (pcnt_q == '0) state_d = (SETTLE > 0) ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (scnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    cmd_d    = cmd_q;
    active_d = active_q;
    qm_d     = qm_q;
    tgt_d    = tgt_q;
    pcnt_d   = pcnt_q;
    scnt_d   = scnt_q;
    ccnt_d   = ccnt_q;
    ecnt_d   = ecnt_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (issue) begin
            cmd_d    = fifo_dat ? 2'b10 : 2'b01;
            active_d = 1'b1;
            tgt_d    = fifo_dat;
            pcnt_d   = PW'(PULSE - 1);
          end else if (ecnt_q != 8'hFF) begin
            ecnt_d = ecnt_q + 8'd1;
          end
        end
      end
      S_ISSUE: begin
        if (pcnt_q == '0) begin
          cmd_d    = 2'b00;
          active_d = 1'b0;
          qm_d     = tgt_q;
          if (ccnt_q != 8'hFF) ccnt_d = ccnt_q + 8'd1;
          if (SETTLE > 0) scnt_d = SW'(SETTLE - 1);
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      S_SETTLE: begin
        if (scnt_q != '0) scnt_d = scnt_q - SW'(1);
      end
      default: begin
        cmd_d    = 2'b00;
        active_d = 1'b0;
      end
    endcase
  end

  // async reset pulls cmd to hold immediately, even mid-pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= 2'b00;
      active_q <= 1'b0;
      qm_q     <= RESET_Q;
      tgt_q    <= RESET_Q;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      ccnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      cmd_q    <= cmd_d;
      active_q <= active_d;
      qm_q     <= qm_d;
      tgt_q    <= tgt_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      ccnt_q   <= ccnt_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_active  = active_q;
  assign bus.q_model     = qm_q;
  assign bus.busy        = !fifo_empty || (state_q != S_IDLE);
  assign bus.cmd_count   = ccnt_q;
  assign bus.elide_count = ecnt_q;
endmodule

// File: tb/tb_sr_cmd_encoder.sv
// Directed bench for sr_cmd_encoder: stimulus pushes expected pulse codes, a negedge monitor scores them.
module tb_sr_cmd_encoder;
  localparam int   DEPTH   = 4;
  localparam int   PULSE   = 2;
  localparam int   SETTLE  = 1;
  localparam logic RESET_Q = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_cmd_encoder_if u_if();

  sr_cmd_encoder #(
    .DEPTH   (DEPTH),
    .PULSE   (PULSE),
    .SETTLE  (SETTLE),
    .RESET_Q (RESET_Q)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_q[$];
  logic       stream[$];
  logic       q_exp = RESET_Q;
  int         cc_exp = 0;
  int         ec_exp = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_min(input string name, input int act, input int min_val);
    total++;
    if (act < min_val) begin
      bad++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min_val);
    end
  endtask

  // reference model, applied at the accept edge; force_en is held steady until the FIFO drains
  task automatic model_accept(input logic b);
    if ((b != q_exp) || u_if.force_en) begin
      exp_q.push_back(b ? 2'b10 : 2'b01);
      q_exp = b;
      if (cc_exp < 255) cc_exp++;
    end else if (ec_exp < 255) begin
      ec_exp++;
    end
  endtask

  // entered and left at #1 after a rising edge
  task automatic drive_stream(output int first_block);
    int   guard;
    int   acc;
    logic rdy;
    guard = 0;
    acc = 0;
    first_block = -1;
    while (stream.size() > 0 && guard < 5000) begin
      u_if.in_valid = 1'b1;
      u_if.in_bit   = stream[0];
      rdy = u_if.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        model_accept(stream.pop_front());
        acc++;
      end else if (first_block < 0) begin
        first_block = acc;
      end
      guard++;
    end
    u_if.in_valid = 1'b0;
    if (stream.size() != 0) begin
      check("stream drain timeout", stream.size(), 0);
      stream.delete();
    end
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (u_if.busy && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check(name, u_if.busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    q_exp = RESET_Q;
    cc_exp = 0;
    ec_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // monitor: measures each non-zero cmd run and the idle gap before it
  int         run_len = 0;
  int         gap = 0;
  bit         have_prev = 1'b0;
  logic [1:0] run_code = 2'b00;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len   = 0;
      gap       = 0;
      have_prev = 1'b0;
    end else if (u_if.cmd != 2'b00) begin
      if (run_len == 0) begin
        if (have_prev) check_min("pulse gap", gap, SETTLE + 1);
        run_code = u_if.cmd;
      end
      run_len++;
    end else begin
      if (run_len > 0) begin
        if (exp_q.size() == 0) check("unexpected pulse", 1, 0);
        else                   check("pulse code", run_code, exp_q.pop_front());
        check("pulse length", run_len, PULSE);
        run_len   = 0;
        gap       = 0;
        have_prev = 1'b1;
      end
      gap++;
    end
  end

  always @(negedge clk) begin
    assert (u_if.cmd != 2'b11) else $error("illegal cmd code 11 driven");
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int fb;
    u_if.in_valid = 1'b1;
    u_if.in_bit   = 1'b1;
    u_if.force_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset held with in_valid asserted
    check("rst cmd", u_if.cmd, 0);
    check("rst cmd_active", u_if.cmd_active, 0);
    check("rst q_model", u_if.q_model, RESET_Q);
    check("rst in_ready", u_if.in_ready, 1);
    check("rst busy", u_if.busy, 0);
    check("rst cmd_count", u_if.cmd_count, 0);
    check("rst elide_count", u_if.elide_count, 0);
    u_if.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst busy", u_if.busy, 0);

    // single set pulse: latency and length
    u_if.in_valid = 1'b1;
    u_if.in_bit   = 1'b1;
    check("t2 in_ready", u_if.in_ready, 1);
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    model_accept(1'b1);
    check("t2 cmd at accept", u_if.cmd, 0);
    @(posedge clk);
    #1;
    check("t2 cmd cycle1", u_if.cmd, 2);
    check("t2 cmd_active", u_if.cmd_active, 1);
    @(posedge clk);
    #1;
    check("t2 cmd cycle2", u_if.cmd, 2);
    check("t2 q_model mid", u_if.q_model, 0);
    @(posedge clk);
    #1;
    check("t2 cmd end", u_if.cmd, 0);
    check("t2 q_model", u_if.q_model, 1);
    wait_idle("t2 idle");
    check("t2 cmd_count", u_if.cmd_count, 1);

    // 1,1,0 from q=0: set, elide, clear
    apply_reset();
    stream = '{1'b1, 1'b1, 1'b0};
    drive_stream(fb);
    wait_idle("t3 idle");
    check("t3 cmd_count", u_if.cmd_count, cc_exp);
    check("t3 elide_count", u_if.elide_count, 1);
    check("t3 q_model", u_if.q_model, 0);

    // forced clear with q already 0
    u_if.force_en = 1'b1;
    stream = '{1'b0};
    drive_stream(fb);
    wait_idle("t5 idle");
    u_if.force_en = 1'b0;
    check("t5 cmd_count", u_if.cmd_count, 3);
    check("t5 elide_count", u_if.elide_count, 1);
    check("t5 q_model", u_if.q_model, 0);

    // continuous valid: first beat is popped into the FSM, so in_ready falls after DEPTH+1 accepts
    stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    drive_stream(fb);
    check("t4 accepts before full", fb, DEPTH + 1);
    wait_idle("t4 idle");
    check("t4 cmd_count", u_if.cmd_count, 9);
    check("t4 elide_count", u_if.elide_count, 3);
    check("t4 q_model", u_if.q_model, q_exp);
    check("t4 scoreboard drained", exp_q.size(), 0);

    // reset dropped mid-cycle during a clear pulse with q_model=1
    stream = '{1'b1};
    drive_stream(fb);
    wait_idle("t6 pre idle");
    check("t6 pre q_model", u_if.q_model, 1);
    stream = '{1'b0};
    drive_stream(fb);
    @(posedge clk);
    #1;
    check("t6 cmd before reset", u_if.cmd, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    q_exp = RESET_Q;
    cc_exp = 0;
    ec_exp = 0;
    #1;
    check("t6 cmd async", u_if.cmd, 0);
    check("t6 cmd_active async", u_if.cmd_active, 0);
    check("t6 q_model async", u_if.q_model, RESET_Q);
    check("t6 busy async", u_if.busy, 0);
    check("t6 cmd_count async", u_if.cmd_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stream = '{1'b1};
    drive_stream(fb);
    wait_idle("t6 resume idle");
    check("t6 resume cmd_count", u_if.cmd_count, 1);
    check("t6 resume q_model", u_if.q_model, 1);

    // counter saturation
    apply_reset();
    for (int i = 0; i < 260; i++) stream.push_back(1'b0);
    drive_stream(fb);
    wait_idle("sat elide idle");
    check("sat elide_count", u_if.elide_count, 255);
    check("sat elide cmd_count", u_if.cmd_count, 0);
    for (int i = 0; i < 260; i++) stream.push_back((i % 2) == 0);
    drive_stream(fb);
    wait_idle("sat cmd idle");
    check("sat cmd_count", u_if.cmd_count, 255);
    check("sat elide hold", u_if.elide_count, 255);
    check("sat q_model", u_if.q_model, q_exp);
    check("final scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
